// File: rtl/bram_port_client_if.sv
// Request/response stream bundle between a pipeline client and bram_port_client.
// The master drives requests and consumes responses. The slave is the port client.
interface bram_port_client_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 36
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/bram_port_client.sv
// Ready/valid front-end for one port of a block RAM with one-cycle registered read.
// Read data falls through when the consumer is ready and is buffered otherwise.
module bram_port_client #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 36,
  parameter int RESP_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bram_port_client_if.slave     bus,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_di,
  input  logic [DATA_WIDTH-1:0] bram_do,
  output logic [31:0]           stat_reads,
  output logic [31:0]           stat_writes
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RESP_DEPTH);

  logic                  inflight_q, inflight_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [31:0]           stat_reads_q, stat_reads_d;
  logic [31:0]           stat_writes_q, stat_writes_d;
  logic [DATA_WIDTH-1:0] fifo_mem [RESP_DEPTH];

  logic [CNT_W-1:0]      occ;
  logic                  accept;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

  // Credit counts the read already issued to the BRAM, so the FIFO can never overflow.
  assign occ           = cnt_q + CNT_W'(inflight_q);
  assign bus.req_ready = rst_n & (occ < DEPTH_C);
  assign accept        = bus.req_valid & bus.req_ready;

  assign bram_en   = accept;
  assign bram_we   = accept & bus.req_write;
  assign bram_addr = bus.req_addr;
  assign bram_di   = bus.req_wdata;

  assign fifo_empty     = (cnt_q == '0);
  assign bus.resp_valid = ~fifo_empty | inflight_q;
  assign bus.resp_rdata = fifo_empty ? bram_do : fifo_mem[rd_ptr_q];

  // bram_do lives for one cycle only: it is taken now or it must be captured.
  assign push = inflight_q & ~(fifo_empty & bus.resp_ready);
  assign pop  = bus.resp_ready & ~fifo_empty;

  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;

  always_comb begin
    inflight_d    = accept & ~bus.req_write;
    cnt_d         = cnt_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d      = wr_ptr_q + PTR_W'(push);
    rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
    stat_reads_d  = stat_reads_q;
    stat_writes_d = stat_writes_q;
    if (accept) begin
      if (bus.req_write) begin
        stat_writes_d = stat_writes_q + 32'd1;
      end else begin
        stat_reads_d = stat_reads_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q    <= 1'b0;
      cnt_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
    end else begin
      inflight_q    <= inflight_d;
      cnt_q         <= cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      stat_reads_q  <= stat_reads_d;
      stat_writes_q <= stat_writes_d;
    end
  end

  // Storage is not reset; the count and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= bram_do;
    end
  end

endmodule

// File: tb/tb_bram_port_client.sv
// Directed and random checks of bram_port_client against a behavioural BRAM
// and a reference memory with an ordered queue of expected read responses.
module tb_bram_port_client;

  localparam int AW = 10;
  localparam int DW = 36;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_di;
  logic [DW-1:0] bram_do;
  logic [31:0]   stat_reads, stat_writes;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bram_port_client_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bram_port_client #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .bram_en     (bram_en),
    .bram_we     (bram_we),
    .bram_addr   (bram_addr),
    .bram_di     (bram_di),
    .bram_do     (bram_do),
    .stat_reads  (stat_reads),
    .stat_writes (stat_writes)
  );

  // Behavioural BRAM port: registered read, output held on writes.
  logic [DW-1:0] bram_mem [1024];
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) bram_mem[bram_addr] <= bram_di;
      else         bram_do <= bram_mem[bram_addr];
    end
  end

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_rv;
    logic [DW-1:0] exp_rd;
    logic [31:0]   exp_sw;
    logic [31:0]   exp_sr;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(int wr, int a, longint wd, int rv, longint rd, int sw, int sr);
    vec_t v;
    v.wr     = 1'(wr);
    v.addr   = AW'(a);
    v.wdata  = DW'(wd);
    v.exp_rv = 1'(rv);
    v.exp_rd = DW'(rd);
    v.exp_sw = 32'(sw);
    v.exp_sr = 32'(sr);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic w, input int a, input logic [DW-1:0] d, input logic rr);
    bus.req_valid  = v;
    bus.req_write  = w;
    bus.req_addr   = AW'(a);
    bus.req_wdata  = d;
    bus.resp_ready = rr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] exp_q [$];

  initial begin
    int n_acc, n_cyc, rd_cnt, wr_cnt;
    logic          rv, rw, rr;
    int            ra;
    logic [DW-1:0] rd_data;

    // Table: each record is one request; exp_* are the outputs seen in that same cycle.
    vecs[0] = mk(1, 5, 36'h912345678, 0, 0, 0, 0);
    vecs[1] = mk(0, 5, 0, 0, 0, 1, 0);
    vecs[2] = mk(1, 0, 0, 1, 36'h912345678, 1, 1);
    for (int i = 1; i < 8; i++) vecs[2+i] = mk(1, i, 3*i, 0, 0, i+1, 1);
    for (int i = 0; i < 8; i++) vecs[10+i] = mk(0, i, 0, (i > 0) ? 1 : 0, (i > 0) ? 3*(i-1) : 0, 9, 1+i);
    vecs[18] = mk(1, 9, 36'hA, 1, 21, 9, 9);
    vecs[19] = mk(0, 9, 0, 0, 0, 10, 9);

    drive(1'b1, 1'b0, 0, '0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_bram_en", 64'(bram_en), 64'd0);
    drive(1'b0, 1'b0, 0, '0, 1'b1);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.req_ready), 64'd1);
    chk("post_rst_stat_r", 64'(stat_reads), 64'd0);
    chk("post_rst_stat_w", 64'(stat_writes), 64'd0);

    for (int i = 0; i < 20; i++) begin
      next_cycle();
      drive(1'b1, vecs[i].wr, int'(vecs[i].addr), vecs[i].wdata, 1'b1);
      @(negedge clk);
      $display("vec %0d: %s addr=%0d wdata=0x%0h resp_valid=%0b rdata=0x%0h", i,
               vecs[i].wr ? "WR" : "RD", vecs[i].addr, vecs[i].wdata, bus.resp_valid, bus.resp_rdata);
      chk("vec_req_ready", 64'(bus.req_ready), 64'd1);
      chk("vec_bram_en", 64'(bram_en), 64'd1);
      chk("vec_bram_we", 64'(bram_we), 64'(vecs[i].wr));
      chk("vec_bram_addr", 64'(bram_addr), 64'(vecs[i].addr));
      chk("vec_bram_di", 64'(bram_di), 64'(vecs[i].wdata));
      chk("vec_resp_valid", 64'(bus.resp_valid), 64'(vecs[i].exp_rv));
      if (vecs[i].exp_rv) chk("vec_resp_rdata", 64'(bus.resp_rdata), 64'(vecs[i].exp_rd));
      chk("vec_stat_w", 64'(stat_writes), 64'(vecs[i].exp_sw));
      chk("vec_stat_r", 64'(stat_reads), 64'(vecs[i].exp_sr));
    end
    next_cycle();
    drive(1'b0, 1'b0, 0, '0, 1'b1);
    @(negedge clk);
    chk("tail_resp_valid", 64'(bus.resp_valid), 64'd1);
    chk("tail_resp_rdata", 64'(bus.resp_rdata), 64'hA);
    chk("tail_bram_en", 64'(bram_en), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("idle_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("tail_stat_w", 64'(stat_writes), 64'd10);
    chk("tail_stat_r", 64'(stat_reads), 64'd10);

    // Stall: reads of 1,2,3 offered with the consumer stalled.
    next_cycle(); drive(1'b1, 1'b0, 1, '0, 1'b0); @(negedge clk);
    $display("stall A: read addr 1 ready=%0b", bus.req_ready);
    chk("stall_a_ready", 64'(bus.req_ready), 64'd1);
    chk("stall_a_en", 64'(bram_en), 64'd1);
    next_cycle(); drive(1'b1, 1'b0, 2, '0, 1'b0); @(negedge clk);
    $display("stall B: read addr 2 ready=%0b", bus.req_ready);
    chk("stall_b_ready", 64'(bus.req_ready), 64'd1);
    chk("stall_b_rv", 64'(bus.resp_valid), 64'd1);
    chk("stall_b_rd", 64'(bus.resp_rdata), 64'd3);
    for (int c = 0; c < 2; c++) begin
      next_cycle(); drive(1'b1, 1'b0, 3, '0, 1'b0); @(negedge clk);
      $display("stall C%0d: read addr 3 ready=%0b", c, bus.req_ready);
      chk("stall_full_ready", 64'(bus.req_ready), 64'd0);
      chk("stall_full_en", 64'(bram_en), 64'd0);
      chk("stall_full_rd", 64'(bus.resp_rdata), 64'd3);
    end
    next_cycle(); drive(1'b1, 1'b0, 3, '0, 1'b1); @(negedge clk);
    $display("stall E: resp 0x%0h ready=%0b", bus.resp_rdata, bus.req_ready);
    chk("stall_e_ready", 64'(bus.req_ready), 64'd0);
    chk("stall_e_rv", 64'(bus.resp_valid), 64'd1);
    chk("stall_e_rd", 64'(bus.resp_rdata), 64'd3);
    next_cycle(); @(negedge clk);
    $display("stall F: resp 0x%0h ready=%0b", bus.resp_rdata, bus.req_ready);
    chk("stall_f_ready", 64'(bus.req_ready), 64'd1);
    chk("stall_f_en", 64'(bram_en), 64'd1);
    chk("stall_f_rd", 64'(bus.resp_rdata), 64'd6);
    next_cycle(); drive(1'b0, 1'b0, 0, '0, 1'b1); @(negedge clk);
    $display("stall G: resp 0x%0h", bus.resp_rdata);
    chk("stall_g_rv", 64'(bus.resp_valid), 64'd1);
    chk("stall_g_rd", 64'(bus.resp_rdata), 64'd9);
    next_cycle(); @(negedge clk);
    chk("stall_h_rv", 64'(bus.resp_valid), 64'd0);

    // Reset while one read is buffered and another is in flight.
    next_cycle(); drive(1'b1, 1'b0, 1, '0, 1'b0);
    next_cycle(); drive(1'b1, 1'b0, 2, '0, 1'b0);
    next_cycle(); drive(1'b1, 1'b0, 3, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    $display("reset mid-op: resp_valid=%0b ready=%0b", bus.resp_valid, bus.req_ready);
    chk("midrst_rv", 64'(bus.resp_valid), 64'd0);
    chk("midrst_ready", 64'(bus.req_ready), 64'd0);
    chk("midrst_en", 64'(bram_en), 64'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 0, '0, 1'b1);
    @(negedge clk);
    chk("rel_ready", 64'(bus.req_ready), 64'd1);
    chk("rel_rv", 64'(bus.resp_valid), 64'd0);
    chk("rel_stat_r", 64'(stat_reads), 64'd0);
    chk("rel_stat_w", 64'(stat_writes), 64'd0);
    next_cycle(); drive(1'b1, 1'b0, 7, '0, 1'b1); @(negedge clk);
    chk("rel_read_rv", 64'(bus.resp_valid), 64'd0);
    next_cycle(); drive(1'b0, 1'b0, 0, '0, 1'b1); @(negedge clk);
    $display("after reset: read addr 7 resp 0x%0h", bus.resp_rdata);
    chk("rel_resp_rv", 64'(bus.resp_valid), 64'd1);
    chk("rel_resp_rd", 64'(bus.resp_rdata), 64'd21);
    next_cycle(); @(negedge clk);
    chk("rel_no_stale", 64'(bus.resp_valid), 64'd0);
    rd_cnt = 1;
    wr_cnt = 0;

    // Random phase: preload addresses 0..15, then mixed traffic.
    for (int a = 0; a < 16; a++) begin
      next_cycle();
      ref_mem[a] = DW'({$urandom, $urandom});
      drive(1'b1, 1'b1, a, ref_mem[a], 1'b1);
      @(negedge clk);
      chk("preload_ready", 64'(bus.req_ready), 64'd1);
      wr_cnt++;
    end
    n_acc = 0;
    n_cyc = 0;
    while (n_acc < 10000 && n_cyc < 60000) begin
      next_cycle();
      rv = ($urandom_range(3) != 0);
      rw = 1'($urandom_range(1));
      ra = int'($urandom_range(15));
      rr = ($urandom_range(3) != 0);
      rd_data = DW'({$urandom, $urandom});
      drive(rv, rw, ra, rd_data, rr);
      @(negedge clk);
      n_cyc++;
      chk("fifo_bound", 64'(dut.cnt_q <= 2'd2), 64'd1);
      if (bus.resp_valid && bus.resp_ready) begin
        if (exp_q.size() == 0) chk("rand_unexpected_resp", 64'd1, 64'd0);
        else chk("rand_rdata", 64'(bus.resp_rdata), 64'(exp_q.pop_front()));
      end
      if (rv && bus.req_ready) begin
        n_acc++;
        if (rw) begin
          ref_mem[ra] = rd_data;
          wr_cnt++;
        end else begin
          exp_q.push_back(ref_mem[ra]);
          rd_cnt++;
        end
      end
    end
    chk("rand_budget", 64'(n_acc), 64'd10000);
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      drive(1'b0, 1'b0, 0, '0, 1'b1);
      @(negedge clk);
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) chk("drain_unexpected_resp", 64'd1, 64'd0);
        else chk("drain_rdata", 64'(bus.resp_rdata), 64'(exp_q.pop_front()));
      end
    end
    $display("random: %0d accepts in %0d cycles, reads=%0d writes=%0d", n_acc, n_cyc, rd_cnt, wr_cnt);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_rv", 64'(bus.resp_valid), 64'd0);
    chk("rand_stat_r", 64'(stat_reads), 64'(rd_cnt));
    chk("rand_stat_w", 64'(stat_writes), 64'(wr_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_port_client.md
# bram_port_client

Ready/valid front-end that drives one port of the team's true-dual-port block RAM (en/we/addr/di in, registered do out, one-cycle read latency). It converts a request stream of reads and writes into BRAM port cycles and returns read data on a backpressurable response stream. Read ordering is preserved, and no read data is lost when the consumer stalls. One instance sits on each BRAM port used by pipeline logic.

## Interface
- ADDR_WIDTH, 10, BRAM port address width
- DATA_WIDTH, 36, BRAM port data width
- RESP_DEPTH, 2, response buffer entries, power of two, minimum 2
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high together with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data, ignored for reads
- resp_valid  out  1  read data available
- resp_ready  in  1  consumer takes data
- resp_rdata  out  DATA_WIDTH  read data
- bram_en  out  1  BRAM port enable
- bram_we  out  1  BRAM port write enable
- bram_addr  out  ADDR_WIDTH  BRAM port address
- bram_di  out  DATA_WIDTH  BRAM port write data
- bram_do  in  DATA_WIDTH  BRAM port registered read data
- stat_reads  out  32  accepted reads, wraps modulo 2^32
- stat_writes  out  32  accepted writes, wraps modulo 2^32

## Operation
- Accept = req_valid & req_ready.
- BRAM drive is combinational from accept:
  - bram_en = accept
  - bram_we = accept & req_write
  - bram_addr = req_addr
  - bram_di = req_wdata
- Writes are posted and produce no response. The BRAM read-during-write output is ignored.
- Read accept sets the `inflight` flag at the next edge. `inflight` is cleared at the next edge unless another read is accepted.
- Credit: occ = fifo_count + inflight.
  - req_ready = rst_n & (occ < RESP_DEPTH), independent of req_valid and req_write.
  - Writes are gated by the same credit, which keeps a single rule.
- Response path uses fall-through:
  - resp_valid = (fifo_count > 0) | inflight
  - resp_rdata = FIFO head when fifo_count > 0, else bram_do
- Cycle with inflight = 1:
  - If fifo_count = 0 and resp_ready = 1, bram_do is consumed directly.
  - Otherwise bram_do is pushed into the FIFO at the edge.
  - The push is mandatory: bram_do is valid only in that cycle and is overwritten by the next enable.
- FIFO pop occurs on resp_valid & resp_ready & (fifo_count > 0). Push and pop in the same cycle leave the count unchanged.
- FIFO pointers wrap modulo RESP_DEPTH. The credit rule guarantees no overflow; the bench asserts fifo_count <= RESP_DEPTH.
- Responses are returned strictly in read-accept order.
- stat counters increment on accept of the matching type.

## Timing
- Reset (rst_n low, asynchronous): inflight = 0, fifo_count = 0, pointers = 0, stat_* = 0. During reset:
  - req_ready = 0
  - resp_valid = 0
  - bram_en = 0, bram_we = 0
- First cycle after rst_n deasserts: req_ready = 1.
- Reset mid-operation discards any in-flight read and all buffered data. No response is produced for those reads after reset.
- Read latency: a read accepted in cycle N gives resp_valid = 1 in cycle N+1 with BRAM data, when no older data is buffered.
- Throughput: with resp_ready held high, one read per cycle sustained with RESP_DEPTH = 2 (steady state occ = 1).
- Write followed by read of the same address in the next cycle returns the new data. Both operations go through the same port in order.
- Stall: with resp_ready low, at most RESP_DEPTH reads are outstanding. req_ready falls in the cycle after the RESP_DEPTH-th accept and rises in the cycle after the first pop.

## Test plan
- Write addr 5 = 0x9_1234_5678, then read addr 5 -> resp_valid exactly 1 cycle after the read accept, resp_rdata = 0x9_1234_5678, stat_writes = 1, stat_reads = 1.
- Preload addr 0..7 with value = addr*3, issue 8 back-to-back reads with resp_ready = 1 -> req_ready never drops, 8 responses on consecutive cycles with values 0, 3, ..., 21.
- resp_ready = 0 with reads of addr 1, 2, 3 offered continuously -> only 2 accepted, req_ready = 0, bram_en = 0 thereafter. Raise resp_ready -> responses for addr 1 then 2, then the addr 3 read is accepted and answered.
- Write addr 9 = 0xA in cycle N, read addr 9 in N+1 -> response 0xA. Write never produces resp_valid.
- Assert rst_n low in the cycle after a read accept, with one entry buffered -> resp_valid = 0 and req_ready = 0 immediately. After release: stat_* = 0, no stale response, next read returns correct data.
- Random mix of 10k reads and writes with random resp_ready against a reference memory model -> every response matches, in order, with no FIFO overflow.
